// File: rtl/vram_pkg.sv
// ----------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the read-only 128x128 video RAM.
//   - Geometry: H_BITS/V_BITS pixel index widths, ADR_W address width, DEPTH.
//   - COLOR_W bits per pixel, ordered {R,G,B}, plus named colour constants.
//   - pixel_color(v, h): the image held in the RAM.
// No ports (package).
// ----------------------------------------------------------------------------
package vram_pkg;

  localparam int unsigned H_BITS  = 7;
  localparam int unsigned V_BITS  = 7;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned ADR_W   = V_BITS + H_BITS;   // 14
  localparam int unsigned DEPTH   = 1 << ADR_W;        // 16384

  localparam logic [COLOR_W-1:0] BLACK   = 3'b000;
  localparam logic [COLOR_W-1:0] BLUE    = 3'b001;
  localparam logic [COLOR_W-1:0] GREEN   = 3'b010;
  localparam logic [COLOR_W-1:0] CYAN    = 3'b011;
  localparam logic [COLOR_W-1:0] RED     = 3'b100;
  localparam logic [COLOR_W-1:0] MAGENTA = 3'b101;
  localparam logic [COLOR_W-1:0] YELLOW  = 3'b110;
  localparam logic [COLOR_W-1:0] WHITE   = 3'b111;

  // One-pixel black frame around a 16x16-pixel tile pattern whose colour is
  // the XOR of the top three bits of row and column.
  function automatic logic [COLOR_W-1:0] pixel_color(
    input logic [V_BITS-1:0] v,
    input logic [H_BITS-1:0] h
  );
    logic border;
    border = (v == '0) || (v == '1) || (h == '0) || (h == '1);
    if (border) begin
      return BLACK;
    end
    return v[V_BITS-1 -: 3] ^ h[H_BITS-1 -: 3];
  endfunction

endpackage

// File: rtl/vram_plane.sv
// ----------------------------------------------------------------------------
// vram_plane
// One 16384x1 synchronous-read ROM plane. BIT selects which colour bit of
// pixel_color() this plane stores (2 = R, 1 = G, 0 = B).
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high clear of the read register only
//   adr_i  : linear pixel address {row, column}
//   rd_o   : registered data bit, one clock after adr_i is sampled
// ----------------------------------------------------------------------------
module vram_plane
  import vram_pkg::*;
#(
  parameter int unsigned BIT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADR_W-1:0] adr_i,
  output logic             rd_o
);

  // Constant table built at elaboration; never written, so reset does not
  // touch it. Only the read register below is cleared.
  logic rom [DEPTH];

  for (genvar v = 0; v < (1 << V_BITS); v++) begin : g_row
    for (genvar h = 0; h < (1 << H_BITS); h++) begin : g_col
      localparam logic [COLOR_W-1:0] PIX = pixel_color(V_BITS'(v), H_BITS'(h));
      assign rom[v * (1 << H_BITS) + h] = PIX[BIT];
    end
  end

  // Power-up value keeps the output defined before the first edge.
  logic rd_q = 1'b0;
  logic rd_d;

  always_comb begin
    rd_d = rom[adr_i];
    if (rst_i) begin
      rd_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    rd_q <= rd_d;
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/vram_module.sv
// ----------------------------------------------------------------------------
// vram_module
// Read-only 128x128 video RAM returning a 3-bit {R,G,B} pixel colour one
// clock after its address is presented. Full throughput: a new address may
// be presented on every cycle.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high; forces out to 000 on every edge it is
//           sampled high (image contents are unaffected)
//   adr   : pixel address, adr[13:7] = row (vpixel), adr[6:0] = column
//   out   : registered pixel colour {R,G,B}
// ----------------------------------------------------------------------------
module vram_module
  import vram_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [ADR_W-1:0]   adr,
  output logic [COLOR_W-1:0] out
);

  logic [V_BITS-1:0] vpixel;
  logic [H_BITS-1:0] hpixel;
  logic [ADR_W-1:0]  rom_adr;
  logic              r_bit;
  logic              g_bit;
  logic              b_bit;

  assign vpixel  = adr[ADR_W-1 -: V_BITS];
  assign hpixel  = adr[H_BITS-1:0];
  assign rom_adr = {vpixel, hpixel};

  // Each plane owns its output register; reset is applied there so the
  // cleared colour appears at the same edge that samples reset.
  vram_plane #(.BIT(2)) u_plane_r (
    .clk_i (clk),
    .rst_i (reset),
    .adr_i (rom_adr),
    .rd_o  (r_bit)
  );

  vram_plane #(.BIT(1)) u_plane_g (
    .clk_i (clk),
    .rst_i (reset),
    .adr_i (rom_adr),
    .rd_o  (g_bit)
  );

  vram_plane #(.BIT(0)) u_plane_b (
    .clk_i (clk),
    .rst_i (reset),
    .adr_i (rom_adr),
    .rd_o  (b_bit)
  );

  assign out = {r_bit, g_bit, b_bit};

endmodule

// File: tb/tb_vram_module.sv
// ----------------------------------------------------------------------------
// tb_vram_module
// Bench for vram_module: clock/reset block, driver task, scoreboard queue
// checked one edge after each drive, final report.
// ----------------------------------------------------------------------------
module tb_vram_module;

  localparam int ADR_W = 14;
  localparam int COL_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [ADR_W-1:0] adr = '0;
  logic [COL_W-1:0] out;

  int errors = 0;
  int checks = 0;

  logic [COL_W-1:0] exp_q[$];
  logic [COL_W-1:0] prev_exp = '0;

  // --------------------------------------------------------------- clock
  always #5 clk = ~clk;

  vram_module dut (
    .clk   (clk),
    .reset (reset),
    .adr   (adr),
    .out   (out)
  );

  // --------------------------------------------------------------- model
  function automatic logic [COL_W-1:0] ref_pixel(input logic [ADR_W-1:0] a);
    int v;
    int h;
    v = int'(a) / 128;
    h = int'(a) % 128;
    if (v == 0 || v == 127 || h == 0 || h == 127) return 3'd0;
    return COL_W'((v / 16) ^ (h / 16));
  endfunction

  task automatic check(input string tag, input logic [COL_W-1:0] got,
                       input logic [COL_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, want, $time);
    end
  endtask

  // --------------------------------------------------------------- driver
  // Drives one cycle at the falling edge. Before changing inputs, out must
  // still hold the result of the previous edge (no early update).
  task automatic drive(input logic [ADR_W-1:0] a, input logic r,
                       input logic [COL_W-1:0] e);
    @(negedge clk);
    check("hold", out, prev_exp);
    adr   = a;
    reset = r;
    exp_q.push_back(e);
    prev_exp = e;
  endtask

  task automatic drive_ref(input logic [ADR_W-1:0] a);
    drive(a, 1'b0, ref_pixel(a));
  endtask

  // --------------------------------------------------------------- scoreboard
  // Every drive is followed by exactly one rising edge, so each edge
  // retires the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      check("pixel", out, exp_q.pop_front());
    end
  end

  // --------------------------------------------------------------- stimulus
  logic [ADR_W-1:0] dir_adr [5];
  logic [COL_W-1:0] dir_exp [5];
  logic [ADR_W-1:0] blk_adr [8];

  initial begin
    dir_adr = '{14'h11c0, 14'h0801, 14'h1021, 14'h2a55, 14'h1911};
    dir_exp = '{3'b110,   3'b001,   3'b000,   3'b000,   3'b010};
    blk_adr = '{14'h0000, 14'h007f, 14'h3f80, 14'h3fff,
                14'(5 * 128 + 127), 14'(1 * 128 + 1),
                14'(126 * 128 + 126), 14'(126 * 128 + 1)};

    #1;
    check("powerup", out, 3'b000);

    // Border pixel with reset low, then reset held.
    repeat (100) drive(14'h0000, 1'b0, 3'b000);
    repeat (100) drive(14'h0000, 1'b1, 3'b000);
    drive(14'h0000, 1'b0, 3'b000);

    // Single address, then back-to-back directed addresses.
    for (int i = 0; i < 5; i++) drive(dir_adr[i], 1'b0, dir_exp[i]);

    // Corners, edge and inner neighbours, with literal expectations.
    for (int i = 0; i < 7; i++) drive(blk_adr[i], 1'b0, 3'b000);
    drive(blk_adr[7], 1'b0, 3'b111);

    // One-cycle reset while streaming random addresses.
    for (int i = 0; i < 6; i++) drive_ref(14'($urandom_range(0, 16383)));
    drive(14'h11c0, 1'b1, 3'b000);
    drive(14'h11c0, 1'b0, 3'b110);
    for (int i = 0; i < 6; i++) drive_ref(14'($urandom_range(0, 16383)));

    // Reset asserted for several cycles mid-stream.
    for (int i = 0; i < 3; i++) drive(14'($urandom_range(0, 16383)), 1'b1, 3'b000);
    drive(14'h0801, 1'b0, 3'b001);

    // Exhaustive sweep.
    for (int a = 0; a < 16384; a++) drive_ref(14'(a));

    // Random order tail.
    for (int i = 0; i < 200; i++) drive_ref(14'($urandom_range(0, 16383)));

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
